// File: rtl/sumador_serie_if.sv
// Operand/result bundle for the bit-serial adder.
// Latency: none, plain wires between requester and adder.
// Backpressure: none; start is ignored while busy, the requester watches busy/done.
//
// Signals:
//   start  request, sampled by the adder only while idle
//   A, B   N-bit operands, captured on an accepted start
//   S, Co  registered sum and carry-out, valid from done onward
//   busy   high from the cycle after acceptance through the done cycle
//   done   one-cycle pulse, S/Co valid
interface sumador_serie_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] S;
    logic         Co;
    logic         busy;
    logic         done;

    // Requester side: drives the operands, watches the result.
    modport master (
        output start,
        output A,
        output B,
        input  S,
        input  Co,
        input  busy,
        input  done
    );

    // Adder side.
    modport slave (
        input  start,
        input  A,
        input  B,
        output S,
        output Co,
        output busy,
        output done
    );
endinterface

// File: rtl/sumador_serie.sv
// Bit-serial unsigned N-bit adder, one operand bit pair per clock, LSB first.
// Latency: done pulses N+1 cycles after the start cycle (N add cycles + 1 finish cycle).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, wins over everything
//   bus   sumador_serie_if.slave: start/A/B in, S/Co/busy/done out

// Half adder cell; two of these plus an OR form the full-adder slice.
module medio_sumador (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module sumador_serie #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    sumador_serie_if.slave      bus
);
    localparam int             CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } estado_t;

    estado_t       estado;
    estado_t       estado_sig;

    // Datapath state
    logic [N-1:0]  sha;
    logic [N-1:0]  shb;
    logic [N-1:0]  shs;
    logic          c_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  s_q;
    logic          co_q;

    // FSM controls
    logic          load;
    logic          step;
    logic          busy;
    logic          done;

    // Full-adder slice for the current bit
    logic          hs1;
    logic          hc1;
    logic          s_bit;
    logic          hc2;
    logic          c_sig;
    logic [N-1:0]  shs_sig;

    medio_sumador u_ms0 (
        .a (sha[0]),
        .b (shb[0]),
        .s (hs1),
        .c (hc1)
    );

    medio_sumador u_ms1 (
        .a (hs1),
        .b (c_q),
        .s (s_bit),
        .c (hc2)
    );

    assign c_sig = hc1 | hc2;

    // Sum bits enter from the MSB side so that after N shifts bit 0 sits at [0].
    generate
        if (N == 1) begin : g_shs_1
            assign shs_sig = s_bit;
        end else begin : g_shs_n
            assign shs_sig = {s_bit, shs[N-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        estado_sig = estado;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (estado)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    estado_sig = SUMA;
                end
            end
            SUMA: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    estado_sig = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                estado_sig = IDLE;
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    // Datapath. The carry FF is cleared on every load so a previous overflow
    // never leaks into the next sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sha  <= '0;
            shb  <= '0;
            shs  <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
            s_q  <= '0;
            co_q <= 1'b0;
        end else if (load) begin
            sha  <= bus.A;
            shb  <= bus.B;
            shs  <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
        end else if (step) begin
            sha  <= sha >> 1;
            shb  <= shb >> 1;
            shs  <= shs_sig;
            c_q  <= c_sig;
            cnt  <= cnt + CW'(1);
            // Result registers update only on FIN entry; partial sums stay hidden.
            if (cnt == LAST) begin
                s_q  <= shs_sig;
                co_q <= c_sig;
            end
        end
    end

    assign bus.S    = s_q;
    assign bus.Co   = co_q;
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie at N=4 and N=1.
// Latency: expects done N+1 cycles after the start cycle, S/Co = A+B.
// Backpressure: exercises a dropped start while busy and a back-to-back start.
module tb_sumador_serie;
    logic clk;
    logic rst;

    int n_checks;
    int n_fails;

    sumador_serie_if #(.N(4)) bus4 ();
    sumador_serie_if #(.N(1)) bus1 ();

    sumador_serie #(.N(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    sumador_serie #(.N(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one start pulse on the selected instance and wait for done.
    // Returns cycles from the start cycle to the done cycle, number of busy
    // cycles seen, whether S changed before done, and the result.
    task automatic run_op(input int w, input int a, input int b, input bit ghost,
                          output int lat, output int nbusy, output bit s_moved,
                          output int s, output int co);
        int s_before;
        @(posedge clk);
        #1;
        if (w == 4) begin
            bus4.start = 1'b1; bus4.A = 4'(a); bus4.B = 4'(b);
        end else begin
            bus1.start = 1'b1; bus1.A = 1'(a); bus1.B = 1'(b);
        end
        s_before = (w == 4) ? int'(bus4.S) : int'(bus1.S);
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        lat     = 0;
        nbusy   = 0;
        s_moved = 1'b0;
        s       = -1;
        co      = -1;
        for (int i = 0; i < 20; i++) begin
            // Optional second request with different operands while busy.
            if (ghost && i == 1 && w == 4) begin
                bus4.start = 1'b1; bus4.A = 4'd1; bus4.B = 4'd1;
            end else begin
                bus4.start = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (w == 4) begin
                if (bus4.busy) nbusy++;
                if (bus4.done) begin
                    s = int'(bus4.S); co = int'(bus4.Co);
                    break;
                end
                if (int'(bus4.S) != s_before) s_moved = 1'b1;
            end else begin
                if (bus1.busy) nbusy++;
                if (bus1.done) begin
                    s = int'(bus1.S); co = int'(bus1.Co);
                    break;
                end
                if (int'(bus1.S) != s_before) s_moved = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus4.start = 1'b0;
        if (s < 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout_n%0d: got no done, expected done within 20 cycles", w);
        end
    endtask

    // Reference model: plain unsigned addition with N-bit wrap.
    task automatic op_and_check(input string tag, input int w, input int a, input int b,
                                input bit ghost);
        int lat, nbusy, s, co, sum;
        bit moved;
        sum = a + b;
        run_op(w, a, b, ghost, lat, nbusy, moved, s, co);
        check({tag, "_lat"}, lat, w + 1);
        check({tag, "_busy"}, nbusy, w + 1);
        check({tag, "_hidden"}, moved, 0);
        check({tag, "_S"}, s, sum % (1 << w));
        check({tag, "_Co"}, co, sum >> w);
    endtask

    initial begin
        int a, b;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
        bus1.start = 1'b0; bus1.A = '0; bus1.B = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_S4", bus4.S, 0);
        check("rst_Co4", bus4.Co, 0);
        check("rst_busy4", bus4.busy, 0);
        check("rst_done4", bus4.done, 0);
        check("rst_S1", bus1.S, 0);
        check("rst_busy1", bus1.busy, 0);

        // Directed cases
        op_and_check("d5p3", 4, 5, 3, 1'b0);
        @(negedge clk);
        check("done_width", bus4.done, 0);
        check("s_hold", bus4.S, 8);
        op_and_check("d15p1", 4, 15, 1, 1'b0);
        op_and_check("d15p15", 4, 15, 15, 1'b0);
        op_and_check("d0p0", 4, 0, 0, 1'b0);
        op_and_check("ghost", 4, 6, 7, 1'b1);
        // The dropped request must not start a second operation.
        @(negedge clk);
        check("ghost_idle", bus4.busy, 0);

        // Reset mid-operation: prime S with a nonzero result first.
        op_and_check("pre_rst", 4, 15, 15, 1'b0);
        @(posedge clk);
        #1;
        bus4.start = 1'b1; bus4.A = 4'd9; bus4.B = 4'd9;
        @(posedge clk);              // SUMA cycle 1 follows
        #1;
        bus4.start = 1'b0;
        @(posedge clk);              // SUMA cycle 2
        #1;
        @(posedge clk);              // SUMA cycle 3
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_S", bus4.S, 0);
        check("mrst_Co", bus4.Co, 0);
        check("mrst_busy", bus4.busy, 0);
        check("mrst_done", bus4.done, 0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus4.done || bus4.busy) seen++;
            end
            check("mrst_no_done", seen, 0);
        end
        op_and_check("post_rst", 4, 9, 9, 1'b0);

        // N=1, including back-to-back starts right after done
        op_and_check("n1_1p1", 1, 1, 1, 1'b0);
        op_and_check("n1_b2b", 1, 1, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 1));
            b = int'($urandom_range(0, 1));
            op_and_check($sformatf("n1_rnd%0d", i), 1, a, b, 1'b0);
        end

        // Randomized N=4
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            op_and_check($sformatf("n4_rnd%0d", i), 4, a, b, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
